// File: rtl/lif_pkg.sv
// Shared constants, state encoding and LFSR step function for the LIF rate encoder.
package lif_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;
    localparam int INTENSITY_BITS = 8;

    typedef enum logic {
        IDLE,
        GEN
    } state_t;

    // Right-shifting Galois step: the bit shifted out decides whether the taps are applied.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] value);
        logic [LFSR_WIDTH-1:0] shifted;
        shifted = value >> 1;
        return value[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lif_lfsr16.sv
// 16-bit Galois LFSR with reseed; the advanced value is exposed combinationally
// so the consumer can use it in the same cycle the register steps.
module lif_lfsr16
    import lif_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  load_seed,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] next_value,
    output logic [LFSR_WIDTH-1:0] state
);

    assign next_value = lfsr_advance(state);

    // Reseed has priority; the encoder never requests both in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load_seed) begin
            state <= seed;
        end else if (advance) begin
            state <= next_value;
        end
    end

endmodule

// File: rtl/lif_rate_encoder.sv
// Bernoulli rate encoder: one channel per cycle compares its intensity against a
// shared LFSR, and the assembled spike vector is published once all channels are done.
module lif_rate_encoder
    import lif_pkg::*;
#(
    parameter int              N_INPUTS = 4,
    parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          load_valid,
    input  logic [$clog2(N_INPUTS)-1:0]   load_addr,
    input  logic [INTENSITY_BITS-1:0]     load_data,
    output logic                          load_ready,
    input  logic                          reseed,
    input  logic                          step,
    output logic                          busy,
    output logic [N_INPUTS-1:0]           spikes_out,
    output logic                          spikes_valid
);

    localparam int CH_W = $clog2(N_INPUTS);

    state_t                    state;
    logic [CH_W-1:0]           ch;
    logic [N_INPUTS-1:0]       partial;
    logic [N_INPUTS-1:0]       assembled;
    logic [INTENSITY_BITS-1:0] intensity [N_INPUTS];

    logic                  lfsr_advance_en;
    logic                  lfsr_load_seed;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                  hit;
    logic                  last_channel;
    logic                  unused_lfsr_bits;

    assign load_ready      = !busy;
    assign lfsr_advance_en = ena && (state == GEN);
    assign lfsr_load_seed  = ena && reseed && (state == IDLE);
    assign hit             = lfsr_next[INTENSITY_BITS-1:0] < intensity[ch];
    assign last_channel    = (ch == CH_W'(N_INPUTS - 1));
    assign unused_lfsr_bits = &{1'b0, lfsr_state, lfsr_next[LFSR_WIDTH-1:INTENSITY_BITS]};

    lif_lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (lfsr_advance_en),
        .load_seed (lfsr_load_seed),
        .seed      (SEED),
        .next_value(lfsr_next),
        .state     (lfsr_state)
    );

    always_comb begin
        assembled     = partial;
        assembled[ch] = hit;
    end

    // Intensities are only writable while idle, so a step always sees a stable table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                intensity[i] <= '0;
            end
        end else if (ena && load_valid && load_ready) begin
            intensity[load_addr] <= load_data;
        end
    end

    // spikes_valid drops on every edge so the publish pulse is one cycle even if ena falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            partial      <= '0;
            busy         <= 1'b0;
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
        end else begin
            spikes_valid <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (step) begin
                            state   <= GEN;
                            ch      <= '0;
                            partial <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    GEN: begin
                        partial <= assembled;
                        ch      <= ch + CH_W'(1);
                        if (last_channel) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            spikes_out   <= assembled;
                            spikes_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/lif_rate_encoder.md
Name: lif_rate_encoder

Overview:
- Upstream stage of the LIF neuron. Converts per-channel 8-bit intensities into one stochastic spike vector per step (Bernoulli rate coding).
- Each channel is compared against a shared 16-bit Galois LFSR.
- Channels are evaluated time-multiplexed, one per cycle. The resulting vector drives the neuron's `inputs` register.

Parameters:
- N_INPUTS, 4, number of spike channels (power of two, 2..16).
- SEED, 16'hACE1, LFSR reset/reseed value (must be nonzero).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  global enable; low freezes all state (no load, step, reseed or LFSR advance)
- load_valid  input  1  write load_data to intensity[load_addr]
- load_addr  input  $clog2(N_INPUTS)  channel index
- load_data  input  8  intensity 0..255
- load_ready  output  1  equals !busy; load accepted only when load_valid && load_ready && ena
- reseed  input  1  pulse; reload LFSR with SEED (IDLE only)
- step  input  1  pulse; request one spike vector (IDLE only)
- busy  output  1  high while in GEN
- spikes_out  output  N_INPUTS  last generated vector, bit i = channel i; held between steps
- spikes_valid  output  1  one-cycle pulse when spikes_out updates

Behaviour:
- Reset (async, rst_n=0):
  - lfsr=SEED, all intensities=0, spikes_out=0, spikes_valid=0.
  - state=IDLE, ch=0, busy=0, load_ready=1.
  - Reset mid-GEN aborts immediately; the partial vector is discarded.
- LFSR: 16-bit Galois, right shift, taps mask 16'hB400. Advance rule:
  - lsb=lfsr[0]; lfsr=lfsr>>1; if lsb then lfsr ^= 16'hB400.
  - Advances only in GEN, one step per cycle.
- State machine, IDLE -> GEN:
  - Triggered by ena && step sampled in IDLE.
  - At that edge: ch<=0, busy<=1, spikes_valid<=0.
- GEN, each cycle with ena=1:
  - nxt = advanced LFSR value; lfsr<=nxt.
  - bit[ch] = (nxt[7:0] < intensity[ch]), unsigned.
  - ch increments.
  - intensity 0 never fires; 255 fires with probability 255/256.
- GEN -> IDLE: on the edge that evaluates ch=N_INPUTS-1:
  - spikes_out <= assembled vector; spikes_valid <= 1 for exactly one cycle; busy <= 0.
- Timing:
  - step sampled at edge E0; channels evaluated at edges E1..EN; spikes_valid high in the cycle after EN.
  - Next step can be sampled at EN+1, giving N_INPUTS+1 cycles per vector back-to-back.
- ena=0 in GEN stalls: ch and lfsr hold, spikes_valid forced 0; resumes when ena returns.
- step while busy: ignored, not queued.
- reseed: accepted only in IDLE (ignored in GEN).
  - reseed and step in the same IDLE cycle: lfsr<=SEED and GEN starts; first evaluation uses the advance from SEED.
- Load:
  - Accepted in IDLE only; ignored while busy.
  - Load and step in the same cycle: the write lands at E0 and is used in this step.
  - Multiple loads to one address: last one wins.
- spikes_valid and load_ready are registered/derived without combinational paths from inputs, except load_ready = !busy.

Decomposition:
- Package lif_pkg:
  - LFSR_WIDTH=16, LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1, INTENSITY_BITS=8.
  - State enum {IDLE, GEN}.
- Sub-module lif_lfsr16: ports clk, rst_n, advance, load_seed, seed, next_value, state.
  - Combinational next_value exposed so the encoder compares the advanced value in the same cycle.

Test Plan:
- Reset value check: after reset, observe outputs for 10 idle cycles -> spikes_out=0, spikes_valid=0, busy=0, load_ready=1.
- Known-vector check:
  - Reset, load intensities {0x80,0x30,0xA0,0x4E} to ch0..3, pulse step.
  - LFSR low bytes are 0x70, 0x38, 0x9C, 0x4E -> spikes_out=4'b0101, spikes_valid pulses exactly once, 4 cycles after the step edge.
  - Second step: next low bytes checked against the golden LFSR model.
- Boundary intensities: all 0 -> 1000 steps give spikes_out=0. All 255 -> per-channel fire count within 1000*(255/256) ± 3σ. All 128 -> ~50%.
- Handshake rules:
  - step held high continuously -> one vector per 5 cycles.
  - Load and step issued while busy -> ignored: intensity unchanged, no extra spikes_valid.
  - ena=0 for 3 cycles mid-GEN -> same vector as the unstalled golden run, delayed by 3 cycles.
- Reseed determinism: run 3 steps, reseed, run 3 steps -> the second triple equals the first. reseed+step in the same cycle -> first vector equals the post-reset first vector.
- Abort and recovery: rst_n low mid-GEN (after 2 channels) -> spikes_valid never asserted, all registers at reset values asynchronously. Then a step with intensities {0x80,0x30,0xA0,0x4E} reloaded -> 4'b0101.
